fp16_to_fixed_pipe: RTL and testbench
=====================================

Name: fp16_to_fixed_pipe

Overview:
- 3-stage pipelined converter from IEEE-754 half precision (1/5/10, bias 15) to signed two's-complement fixed point.
- Decode-side counterpart of the FP16 adder pipeline: it consumes FP16 sums and produces integer or fixed-point values for downstream integer datapaths.
- Every input word carries a valid qualifier. Results have a fixed latency and carry status flags.

Parameters:
- OUT_W, 16, output width in bits; legal range 8..32.
- FRAC_W, 0, fractional bits of the output; legal range 0..OUT_W-2. Result = round(value * 2^FRAC_W).

Ports:
- clk73  input  1  clock; all state updates on rising edge.
- rst73  input  1  synchronous, active-high reset.
- in_valid73  input  1  fp_in73 is valid this cycle.
- fp_in73  input  16  FP16 operand {sign, exp[4:0], mant[9:0]}.
- out_valid73  output  1  result/flags valid.
- fix_out73  output  OUT_W  signed fixed-point result.
- ovf73  output  1  result saturated (overflow or infinity).
- nan73  output  1  input was NaN.
- inexact73  output  1  nonzero bits discarded by rounding.

Behaviour:
- Reset: rst73 sampled high at a rising edge clears all stage valids and data registers. After that edge, out_valid73=0, fix_out73=0, ovf73=0, nan73=0, inexact73=0.
  - Reset mid-stream discards all in-flight words; nothing emerges afterwards.
  - rst73 has priority over in_valid73 on the same edge.
- Latency: a word sampled at edge N appears at the outputs after edge N+3.
  - Throughput is 1 word/cycle.
  - Bubbles (in_valid73=0) propagate as out_valid73=0.
  - Outputs hold their last value while out_valid73=0. The bench must not check data when invalid.
- Stage 1 (unpack): register sign, exp, mant, and the class (zero, subnormal, normal, inf, NaN).
  - Normal: significand = {1, mant}, unbiased exponent E = exp-15.
  - Subnormal: significand = {0, mant}, E = -14.
- Stage 2 (align): shift = E - 10 + FRAC_W.
  - shift >= 0: left-shift the significand. Detect overflow when any bit reaches bit OUT_W-1 or above of the magnitude, before sign handling.
  - shift < 0: right-shift. Keep guard bit, round bit, and sticky (OR of all lower bits).
  - Shifts beyond the internal width collapse fully to sticky, or to overflow. No wrap-around of the shift amount.
- Stage 3 (round/sign/saturate):
  - Round the magnitude to nearest, ties to even. inexact73 = guard | sticky.
  - Rounding carry may create overflow.
  - Negate if sign=1.
  - Saturation range is [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - Negative magnitude exactly 2^(OUT_W-1) is legal: no ovf73, result is the most-negative code.
  - Positive magnitude >= 2^(OUT_W-1) gives the max code with ovf73=1.
  - Negative magnitude > 2^(OUT_W-1) gives the min code with ovf73=1.
- Specials:
  - +/-0 gives 0, no flags.
  - +/-Inf gives max/min code, ovf73=1, inexact73=0.
  - NaN (exp=31, mant!=0) gives 0, nan73=1, ovf73=0, inexact73=0.
  - On overflow, inexact73=0.
- Flags are meaningful only with out_valid73=1. At most one of ovf73/nan73 is set per word.

Optional Feature:
- Macro FP2FIX_STALL_EN.
- Defined: adds port out_ready73 (input, 1) and in_ready73 (output, 1).
  - Global stall: when out_valid73=1 and out_ready73=0, all stages hold.
  - in_ready73 = !(out_valid73 & !out_ready73), combinational.
  - An input is accepted only when in_valid73 & in_ready73.
  - Output data and flags stay stable until accepted. No word is lost or duplicated.
  - rst73 still clears everything, including while stalled.
- Undefined: neither port exists. The pipeline always advances; behaviour is exactly as above.

Test Plan:
- OUT_W=16, FRAC_W=0; one word each of 0x3C00, 0xC000, 0x8000 -> after 3 cycles, in order: 0x0001, 0xFFFE, 0x0000, all flags 0.
- 0x3E00 (1.5), 0x4100 (2.5), 0x0001 (min subnormal) -> 0x0002 inexact73=1; 0x0002 inexact73=1; 0x0000 inexact73=1.
- 0x7800 (+32768), 0xF800 (-32768), 0x7BFF (65504) -> 0x7FFF ovf73=1; 0x8000 ovf73=0; 0x7FFF ovf73=1.
- 0x7C00, 0xFC00, 0x7E00 -> 0x7FFF ovf73=1; 0x8000 ovf73=1; 0x0000 nan73=1.
- FRAC_W=8: 0x3E00 -> 0x0180 exact. 20-word back-to-back stream with random bubbles -> outputs match the reference model in order, latency exactly 3. Assert rst73 with 2 words in flight -> out_valid73=0 on following cycles, no stale output.
- FP2FIX_STALL_EN defined: hold out_ready73=0 for 5 cycles with 3 words in flight -> fix_out73 stable, in_ready73=0. Release -> 3 words delivered once each, in order.

Source files
------------

// File: rtl/fp16_to_fixed_pipe_if.sv
`timescale 1ns/1ps
// Handshake and data bundle for fp16_to_fixed_pipe.
// Building with FP2FIX_STALL_EN adds the out_ready73/in_ready73 back-pressure pair.
interface fp16_to_fixed_pipe_if #(
    parameter int OUT_W = 16
);
    logic             in_valid73;
    logic [15:0]      fp_in73;
    logic             out_valid73;
    logic [OUT_W-1:0] fix_out73;
    logic             ovf73;
    logic             nan73;
    logic             inexact73;
`ifdef FP2FIX_STALL_EN
    logic             out_ready73;
    logic             in_ready73;

    modport master (
        output in_valid73, fp_in73, out_ready73,
        input  out_valid73, fix_out73, ovf73, nan73, inexact73, in_ready73
    );
    modport slave (
        input  in_valid73, fp_in73, out_ready73,
        output out_valid73, fix_out73, ovf73, nan73, inexact73, in_ready73
    );
`else
    modport master (
        output in_valid73, fp_in73,
        input  out_valid73, fix_out73, ovf73, nan73, inexact73
    );
    modport slave (
        input  in_valid73, fp_in73,
        output out_valid73, fix_out73, ovf73, nan73, inexact73
    );
`endif
endinterface

// File: rtl/fp16_to_fixed_pipe.sv
`timescale 1ns/1ps
// FP16 (1/5/10, bias 15) to signed fixed-point converter.
// Input capture register followed by unpack, align and round/saturate stages:
// a word sampled at edge N is presented after edge N+3, one word per cycle.
// Optional macro FP2FIX_STALL_EN adds a global stall driven by out_ready73.
module fp16_to_fixed_pipe #(
    parameter int OUT_W  = 16,
    parameter int FRAC_W = 0
) (
    input  logic                clk73,
    input  logic                rst73,
    fp16_to_fixed_pipe_if.slave bus
);
    typedef enum logic [2:0] {CLS_ZERO, CLS_SUB, CLS_NORM, CLS_INF, CLS_NAN} fp_class_e;

    // Right shifts up to PAD positions keep every significand bit visible to sticky.
    localparam int                PAD      = 40;
    localparam logic signed [7:0] FRAC_S   = 8'(FRAC_W);
    localparam logic [OUT_W:0]    LIM      = {2'b01, {(OUT_W-1){1'b0}}};
    localparam logic [OUT_W-1:0]  MAX_CODE = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0]  MIN_CODE = {1'b1, {(OUT_W-1){1'b0}}};

    logic advance;

    logic        in_v;
    logic [15:0] in_w;

    fp_class_e         s1_cls_c, s1_cls;
    logic [10:0]       s1_sig_c, s1_sig;
    logic signed [7:0] e_unb_c, s1_shift_c, s1_shift;
    logic              s1_v, s1_sign;

    logic [63:0]       int_c;
    logic [10+PAD:0]   rsh_c;
    logic [7:0]        rs_c;
    logic              g_c, r_c, st_c, hi_c;
    logic              s2_v, s2_sign, s2_hi, s2_g, s2_r, s2_s;
    fp_class_e         s2_cls;
    logic [OUT_W-1:0]  s2_mag;

    logic              rnd_up, sat, ovf_c, nan_c, inx_c;
    logic [OUT_W:0]    mag_r;
    logic [OUT_W-1:0]  res_c;
    logic              out_v, out_ovf, out_nan, out_inx;
    logic [OUT_W-1:0]  out_fix;

`ifdef FP2FIX_STALL_EN
    assign advance        = !(out_v && !bus.out_ready73);
    assign bus.in_ready73 = advance;
`else
    assign advance = 1'b1;
`endif

    // Capture the incoming word; rst73 wins over in_valid73.
    // NOTE: state registers use non-blocking assignments so every stage samples pre-edge values.
    always_ff @(posedge clk73) begin
        if (rst73) begin
            in_v <= 1'b0;
            in_w <= '0;
        end else if (advance) begin
            in_v <= bus.in_valid73;
            in_w <= bus.fp_in73;
        end
    end

    // Unpack: classify and form significand plus signed alignment shift.
    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        s1_cls_c = CLS_NORM;
        s1_sig_c = {1'b1, in_w[9:0]};
        e_unb_c  = $signed({3'b000, in_w[14:10]}) - 8'sd15;
        if (in_w[14:10] == 5'd0) begin
            s1_sig_c = {1'b0, in_w[9:0]};
            e_unb_c  = -8'sd14;
            s1_cls_c = (in_w[9:0] == 10'd0) ? CLS_ZERO : CLS_SUB;
        end else if (in_w[14:10] == 5'd31) begin
            s1_cls_c = (in_w[9:0] == 10'd0) ? CLS_INF : CLS_NAN;
        end
        s1_shift_c = e_unb_c - 8'sd10 + FRAC_S;
    end

    // Stage 1 register.
    always_ff @(posedge clk73) begin
        if (rst73) begin
            s1_v     <= 1'b0;
            s1_sign  <= 1'b0;
            s1_cls   <= CLS_ZERO;
            s1_sig   <= '0;
            s1_shift <= '0;
        end else if (advance) begin
            s1_v     <= in_v;
            s1_sign  <= in_w[15];
            s1_cls   <= s1_cls_c;
            s1_sig   <= s1_sig_c;
            s1_shift <= s1_shift_c;
        end
    end

    // Align: left shift with overflow detect, or right shift keeping guard/round/sticky.
    // Sticky here is the OR of everything below the round bit.
    always_comb begin
        int_c = '0;
        rsh_c = '0;
        g_c   = 1'b0;
        r_c   = 1'b0;
        st_c  = 1'b0;
        hi_c  = 1'b0;
        rs_c  = 8'(-s1_shift);
        if (!s1_shift[7]) begin
            if (s1_shift > 8'sd52)
                hi_c = |s1_sig;
            else
                int_c = 64'(s1_sig) << s1_shift[5:0];
        end else if (rs_c > 8'(PAD)) begin
            st_c = |s1_sig;
        end else begin
            rsh_c = {s1_sig, {PAD{1'b0}}} >> rs_c;
            int_c = 64'(rsh_c[10+PAD:PAD]);
            g_c   = rsh_c[PAD-1];
            r_c   = rsh_c[PAD-2];
            st_c  = |rsh_c[PAD-3:0];
        end
        hi_c = hi_c | (|int_c[63:OUT_W]);
    end

    // Stage 2 register.
    always_ff @(posedge clk73) begin
        if (rst73) begin
            s2_v    <= 1'b0;
            s2_sign <= 1'b0;
            s2_cls  <= CLS_ZERO;
            s2_mag  <= '0;
            s2_hi   <= 1'b0;
            s2_g    <= 1'b0;
            s2_r    <= 1'b0;
            s2_s    <= 1'b0;
        end else if (advance) begin
            s2_v    <= s1_v;
            s2_sign <= s1_sign;
            s2_cls  <= s1_cls;
            s2_mag  <= int_c[OUT_W-1:0];
            s2_hi   <= hi_c;
            s2_g    <= g_c;
            s2_r    <= r_c;
            s2_s    <= st_c;
        end
    end

    // Round to nearest even, apply sign, saturate, and resolve specials.
    always_comb begin
        rnd_up = s2_g & (s2_r | s2_s | s2_mag[0]);
        mag_r  = {1'b0, s2_mag} + {{OUT_W{1'b0}}, rnd_up};
        // A negative magnitude of exactly 2^(OUT_W-1) is the most-negative code, not overflow.
        sat    = s2_hi | (s2_sign ? (mag_r > LIM) : (mag_r >= LIM));
        res_c  = s2_sign ? (-mag_r[OUT_W-1:0]) : mag_r[OUT_W-1:0];
        ovf_c  = 1'b0;
        nan_c  = 1'b0;
        inx_c  = s2_g | s2_r | s2_s;
        if (s2_cls == CLS_NAN) begin
            res_c = '0;
            nan_c = 1'b1;
            inx_c = 1'b0;
        end else if (s2_cls == CLS_INF || sat) begin
            res_c = s2_sign ? MIN_CODE : MAX_CODE;
            ovf_c = 1'b1;
            inx_c = 1'b0;
        end
    end

    // Output register; data and flags only change when a valid word arrives.
    always_ff @(posedge clk73) begin
        if (rst73) begin
            out_v   <= 1'b0;
            out_fix <= '0;
            out_ovf <= 1'b0;
            out_nan <= 1'b0;
            out_inx <= 1'b0;
        end else if (advance) begin
            out_v <= s2_v;
            if (s2_v) begin
                out_fix <= res_c;
                out_ovf <= ovf_c;
                out_nan <= nan_c;
                out_inx <= inx_c;
            end
        end
    end

    assign bus.out_valid73 = out_v;
    assign bus.fix_out73   = out_fix;
    assign bus.ovf73       = out_ovf;
    assign bus.nan73       = out_nan;
    assign bus.inexact73   = out_inx;
endmodule

// File: tb/tb_fp16_to_fixed_pipe.sv
`timescale 1ns/1ps
// Self-checking bench for fp16_to_fixed_pipe: four parameterisations fed the same
// stream, each output compared with an arithmetic reference model.
module tb_fp16_to_fixed_pipe;
    logic clk73 = 1'b0;
    logic rst73;
    always #5 clk73 = ~clk73;

    fp16_to_fixed_pipe_if #(.OUT_W(16)) b0 ();
    fp16_to_fixed_pipe_if #(.OUT_W(16)) b1 ();
    fp16_to_fixed_pipe_if #(.OUT_W(8))  b2 ();
    fp16_to_fixed_pipe_if #(.OUT_W(32)) b3 ();

    fp16_to_fixed_pipe #(.OUT_W(16), .FRAC_W(0))  dut0 (.clk73(clk73), .rst73(rst73), .bus(b0.slave));
    fp16_to_fixed_pipe #(.OUT_W(16), .FRAC_W(8))  dut1 (.clk73(clk73), .rst73(rst73), .bus(b1.slave));
    fp16_to_fixed_pipe #(.OUT_W(8),  .FRAC_W(3))  dut2 (.clk73(clk73), .rst73(rst73), .bus(b2.slave));
    fp16_to_fixed_pipe #(.OUT_W(32), .FRAC_W(20)) dut3 (.clk73(clk73), .rst73(rst73), .bus(b3.slave));

    typedef struct {
        logic [15:0] word;
        int          edge_no;
    } item_t;

    item_t q[$];
    int    n_checks = 0;
    int    n_errors = 0;
    int    edge_cnt = 0;
    bit    strict   = 1'b1;
    bit    rst_prev = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (edge %0d)", tag, got, exp, edge_cnt);
        end
    endtask

    // Value = sig * 2^(E + frac_w), rounded half-to-even, then clamped to the signed range.
    function automatic void model(input logic [15:0] w, input int ow, input int fw,
                                  output logic [31:0] res, output logic ovf,
                                  output logic nan, output logic inx);
        longint sig, mag, d, qt, rem, val, maxv, minv, mask;
        int     ex, e, sh;
        ex   = int'(w[14:10]);
        maxv = (longint'(1) << (ow - 1)) - 1;
        minv = -(longint'(1) << (ow - 1));
        mask = (longint'(1) << ow) - 1;
        ovf  = 1'b0;
        nan  = 1'b0;
        inx  = 1'b0;
        val  = 0;
        if (ex == 31) begin
            if (w[9:0] != 0) nan = 1'b1;
            else begin
                ovf = 1'b1;
                val = w[15] ? minv : maxv;
            end
        end else begin
            sig = (ex == 0) ? longint'(w[9:0]) : longint'(w[9:0]) + 1024;
            e   = (ex == 0) ? -14 : ex - 15;
            sh  = e - 10 + fw;
            if (sh >= 0) mag = sig << sh;
            else begin
                d   = longint'(1) << (-sh);
                qt  = sig / d;
                rem = sig % d;
                mag = qt;
                if (rem * 2 > d || (rem * 2 == d && (qt % 2) == 1)) mag = qt + 1;
                inx = (rem != 0);
            end
            val = w[15] ? -mag : mag;
            if (val > maxv) begin
                val = maxv; ovf = 1'b1; inx = 1'b0;
            end else if (val < minv) begin
                val = minv; ovf = 1'b1; inx = 1'b0;
            end
        end
        res = 32'(val & mask);
    endfunction

    task automatic compare_dut(input string tag, input int ow, input int fw,
                               input logic [31:0] fix, input logic ov, input logic nn,
                               input logic ix, input logic [15:0] w);
        logic [31:0] e_fix;
        logic        e_ovf, e_nan, e_inx;
        string       t;
        model(w, ow, fw, e_fix, e_ovf, e_nan, e_inx);
        t = $sformatf("%s[%04h]", tag, w);
        check({t, ".fix"}, fix, e_fix);
        check({t, ".ovf"}, 32'(ov), 32'(e_ovf));
        check({t, ".nan"}, 32'(nn), 32'(e_nan));
        check({t, ".inexact"}, 32'(ix), 32'(e_inx));
    endtask

    task automatic compare_all(input logic [15:0] w);
        if (b0.out_valid73) compare_dut("d0", 16, 0,  32'(b0.fix_out73), b0.ovf73, b0.nan73, b0.inexact73, w);
        if (b1.out_valid73) compare_dut("d1", 16, 8,  32'(b1.fix_out73), b1.ovf73, b1.nan73, b1.inexact73, w);
        if (b2.out_valid73) compare_dut("d2", 8,  3,  32'(b2.fix_out73), b2.ovf73, b2.nan73, b2.inexact73, w);
        if (b3.out_valid73) compare_dut("d3", 32, 20, 32'(b3.fix_out73), b3.ovf73, b3.nan73, b3.inexact73, w);
    endtask

    task automatic drive(input logic v, input logic [15:0] w);
        b0.in_valid73 = v; b0.fp_in73 = w;
        b1.in_valid73 = v; b1.fp_in73 = w;
        b2.in_valid73 = v; b2.fp_in73 = w;
        b3.in_valid73 = v; b3.fp_in73 = w;
    endtask

    // One clock: drive after the edge, check at the falling edge, book-keep at the next rising edge.
    task automatic cycle(input logic v, input logic [15:0] w, input logic rst, input logic rdy);
        logic exp_v, pop, acc;
        drive(v, w);
        rst73 = rst;
`ifdef FP2FIX_STALL_EN
        b0.out_ready73 = rdy; b1.out_ready73 = rdy; b2.out_ready73 = rdy; b3.out_ready73 = rdy;
`endif
        @(negedge clk73);
        if (rst_prev) begin
            check("rst.valid", 32'(b0.out_valid73), 32'h0);
            check("rst.d0.fix", 32'(b0.fix_out73), 32'h0);
            check("rst.d3.fix", b3.fix_out73, 32'h0);
            check("rst.d0.flags", {29'h0, b0.ovf73, b0.nan73, b0.inexact73}, 32'h0);
        end
        pop = 1'b0;
        if (strict) begin
            exp_v = (q.size() > 0) && (q[0].edge_no + 3 == edge_cnt);
            check("d0.valid", 32'(b0.out_valid73), 32'(exp_v));
            check("d1.valid", 32'(b1.out_valid73), 32'(exp_v));
            check("d2.valid", 32'(b2.out_valid73), 32'(exp_v));
            check("d3.valid", 32'(b3.out_valid73), 32'(exp_v));
            if (exp_v) compare_all(q[0].word);
            pop = exp_v;
        end else if (b0.out_valid73) begin
            if (q.size() == 0) check("spurious.valid", 32'(b0.out_valid73), 32'h0);
            else begin
                compare_all(q[0].word);
                pop = rdy;
            end
        end
        acc = v;
`ifdef FP2FIX_STALL_EN
        check("in_ready", 32'(b0.in_ready73), 32'(!(b0.out_valid73 && !rdy)));
        acc = v && b0.in_ready73;
`endif
        @(posedge clk73);
        edge_cnt++;
        if (rst) q.delete();
        else begin
            if (pop && q.size() > 0) void'(q.pop_front());
            if (acc) q.push_back('{w, edge_cnt});
        end
        rst_prev = rst;
        #1;
    endtask

    function automatic logic [15:0] rand_word();
        logic [15:0] specials [12];
        logic [15:0] w;
        specials = '{16'h0000, 16'h8000, 16'h7C00, 16'hFC00, 16'h7E00, 16'hFE01,
                     16'h7BFF, 16'hFBFF, 16'h0001, 16'h8001, 16'h7800, 16'hF800};
        case ($urandom_range(0, 7))
            0: w = specials[$urandom_range(0, 11)];
            1, 2, 3: w = {1'($urandom), 5'($urandom_range(5, 30)), 10'($urandom)};
            default: w = 16'($urandom);
        endcase
        return w;
    endfunction

    initial begin
        logic [15:0] directed [13];
        int sent;
        directed = '{16'h3C00, 16'hC000, 16'h8000, 16'h3E00, 16'h4100, 16'h0001,
                     16'h7800, 16'hF800, 16'h7BFF, 16'h7C00, 16'hFC00, 16'h7E00, 16'hBC00};
        rst73 = 1'b1;
        drive(1'b0, 16'h0);
`ifdef FP2FIX_STALL_EN
        b0.out_ready73 = 1'b1; b1.out_ready73 = 1'b1; b2.out_ready73 = 1'b1; b3.out_ready73 = 1'b1;
`endif
        @(posedge clk73);
        edge_cnt = 1;
        rst_prev = 1'b1;
        #1;
        cycle(1'b0, 16'h0, 1'b1, 1'b1);

        // Directed words back to back, including rounding ties and saturation edges.
        foreach (directed[i]) cycle(1'b1, directed[i], 1'b0, 1'b1);
        repeat (4) cycle(1'b0, 16'h0, 1'b0, 1'b1);

        // 20-word stream with random bubbles.
        sent = 0;
        while (sent < 20) begin
            if ($urandom_range(0, 3) == 0) cycle(1'b0, 16'h0, 1'b0, 1'b1);
            else begin
                cycle(1'b1, rand_word(), 1'b0, 1'b1);
                sent++;
            end
        end
        repeat (4) cycle(1'b0, 16'h0, 1'b0, 1'b1);

        // Reset with two words in flight and a third offered on the reset edge.
        cycle(1'b1, 16'h4000, 1'b0, 1'b1);
        cycle(1'b1, 16'h4200, 1'b0, 1'b1);
        cycle(1'b1, 16'h4400, 1'b1, 1'b1);
        repeat (5) cycle(1'b0, 16'h0, 1'b0, 1'b1);

        // Long random run.
        repeat (300) cycle(1'($urandom_range(0, 3) != 0), rand_word(), 1'b0, 1'b1);
        repeat (4) cycle(1'b0, 16'h0, 1'b0, 1'b1);

`ifdef FP2FIX_STALL_EN
        strict = 1'b0;
        cycle(1'b1, 16'h3C00, 1'b0, 1'b1);
        cycle(1'b1, 16'hC000, 1'b0, 1'b1);
        cycle(1'b1, 16'h4100, 1'b0, 1'b1);
        repeat (6) cycle(1'b0, 16'h0, 1'b0, 1'b0);
        repeat (6) cycle(1'b0, 16'h0, 1'b0, 1'b1);
        check("stall.drain", 32'(q.size()), 32'h0);
        repeat (200) cycle(1'($urandom_range(0, 2) != 0), rand_word(), 1'b0, 1'($urandom_range(0, 2) != 0));
        repeat (8) cycle(1'b0, 16'h0, 1'b0, 1'b1);
        check("stress.drain", 32'(q.size()), 32'h0);
        cycle(1'b0, 16'h0, 1'b1, 1'b1);
        strict = 1'b1;
        repeat (4) cycle(1'b0, 16'h0, 1'b0, 1'b1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
